veer_trace_fifo: RTL and testbench

Trace capture buffer that sits directly downstream of the core wrapper's instruction-trace port. It registers every retired-instruction, exception and interrupt record presented on the `trace_rv_i_*` signals into a DEPTH-entry FIFO. It drains the records to a bench monitor or log writer over a valid/ready handshake, and keeps retire and drop statistics.

---
 rtl/veer_trace_fifo.sv | 169 ++++++++++++++++
 tb/tb_veer_trace_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/veer_trace_fifo.sv
// rtl/veer_trace_fifo.sv - trace record capture FIFO with retire/drop statistics
//
// Captures every record on the trace_rv_i_* port into a DEPTH-entry FIFO and
// drains it over a valid/ready handshake.
// Optional build macro: VEER_TRACE_FIFO_TVAL_EN adds a trap-value storage column.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   trace_rv_i_*             incoming trace record (valid, insn, address,
//                            exception, ecause, interrupt, tval)
//   flush                    synchronous FIFO clear (counters untouched)
//   cnt_clr                  synchronous statistics clear
//   out_valid / out_ready    head entry handshake
//   out_*                    head entry fields, zero while out_valid=0
//   level                    current occupancy
//   retire_cnt               retired instructions (wrapping)
//   drop_cnt                 dropped records (saturating)
//   overflow                 sticky drop flag
module veer_trace_fifo #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       trace_rv_i_valid_ip,
   input  logic [31:0]                trace_rv_i_insn_ip,
   input  logic [31:0]                trace_rv_i_address_ip,
   input  logic                       trace_rv_i_exception_ip,
   input  logic [4:0]                 trace_rv_i_ecause_ip,
   input  logic                       trace_rv_i_interrupt_ip,
   input  logic [31:0]                trace_rv_i_tval_ip,
   input  logic                       flush,
   input  logic                       cnt_clr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_insn,
   output logic [31:0]                out_address,
   output logic                       out_exception,
   output logic [4:0]                 out_ecause,
   output logic                       out_interrupt,
   output logic [31:0]                out_tval,
   output logic [$clog2(DEPTH):0]     level,
   output logic [CNT_W-1:0]           retire_cnt,
   output logic [CNT_W-1:0]           drop_cnt,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic             overflow_q, overflow_d;

   logic [31:0] insn_mem_q [DEPTH];
   logic [31:0] addr_mem_q [DEPTH];
   logic        exc_mem_q  [DEPTH];
   logic [4:0]  cause_mem_q[DEPTH];
   logic        intr_mem_q [DEPTH];

   logic head_valid;
   logic full;
   logic pop;
   logic push;
   logic drop_ev;
   logic retire_ev;

   always_comb begin
      head_valid = (level_q != '0);
      full       = (level_q == FULL_LVL);
      pop        = head_valid & out_ready;
      // A full FIFO still accepts a record when the head leaves in the same cycle.
      push       = trace_rv_i_valid_ip & ~flush & (~full | pop);
      // Records discarded by flush are not drops.
      drop_ev    = trace_rv_i_valid_ip & ~flush & full & ~pop;
      // Retirement is counted for every plain record, even dropped or flushed ones.
      retire_ev  = trace_rv_i_valid_ip & ~trace_rv_i_exception_ip & ~trace_rv_i_interrupt_ip;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         level_d = level_q + LW'(push) - LW'(pop);
      end
   end

   always_comb begin
      retire_cnt_d = retire_cnt_q;
      drop_cnt_d   = drop_cnt_q;
      overflow_d   = overflow_q;
      if (cnt_clr) begin
         // A same-cycle event survives the clear as a count of one.
         retire_cnt_d = CNT_W'(retire_ev);
         drop_cnt_d   = CNT_W'(drop_ev);
         overflow_d   = drop_ev;
      end else begin
         retire_cnt_d = retire_cnt_q + CNT_W'(retire_ev);
         if (drop_ev && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
         overflow_d = overflow_q | drop_ev;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         retire_cnt_q <= '0;
         drop_cnt_q   <= '0;
         overflow_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         retire_cnt_q <= retire_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         overflow_q   <= overflow_d;
      end
   end

   // Storage contents are don't-care after reset, so the array has no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         insn_mem_q[wr_ptr_q]  <= trace_rv_i_insn_ip;
         addr_mem_q[wr_ptr_q]  <= trace_rv_i_address_ip;
         exc_mem_q[wr_ptr_q]   <= trace_rv_i_exception_ip;
         cause_mem_q[wr_ptr_q] <= trace_rv_i_ecause_ip;
         intr_mem_q[wr_ptr_q]  <= trace_rv_i_interrupt_ip;
      end
   end

`ifdef VEER_TRACE_FIFO_TVAL_EN
   logic [31:0] tval_mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (push) tval_mem_q[wr_ptr_q] <= trace_rv_i_tval_ip;
   end

   assign out_tval = head_valid ? tval_mem_q[rd_ptr_q] : 32'h0;
`else
   logic unused_tval;
   assign unused_tval = ^trace_rv_i_tval_ip;
   assign out_tval    = 32'h0;
`endif

   assign out_valid     = head_valid;
   assign out_insn      = head_valid ? insn_mem_q[rd_ptr_q]  : 32'h0;
   assign out_address   = head_valid ? addr_mem_q[rd_ptr_q]  : 32'h0;
   assign out_exception = head_valid ? exc_mem_q[rd_ptr_q]   : 1'b0;
   assign out_ecause    = head_valid ? cause_mem_q[rd_ptr_q] : 5'h0;
   assign out_interrupt = head_valid ? intr_mem_q[rd_ptr_q]  : 1'b0;
   assign level         = level_q;
   assign retire_cnt    = retire_cnt_q;
   assign drop_cnt      = drop_cnt_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_veer_trace_fifo.sv
// tb/tb_veer_trace_fifo.sv - self-checking bench for veer_trace_fifo
module tb_veer_trace_fifo;

   localparam int DEPTH = 16;
   localparam int CNT_W = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        v_i = 1'b0;
   logic [31:0] insn_i = '0;
   logic [31:0] addr_i = '0;
   logic        exc_i = 1'b0;
   logic [4:0]  ec_i = '0;
   logic        intr_i = 1'b0;
   logic [31:0] tval_i = '0;
   logic        flush = 1'b0;
   logic        cnt_clr = 1'b0;
   logic        out_ready = 1'b0;

   logic        out_valid;
   logic [31:0] out_insn, out_address, out_tval;
   logic        out_exception, out_interrupt;
   logic [4:0]  out_ecause;
   logic [$clog2(DEPTH):0] level;
   logic [CNT_W-1:0] retire_cnt, drop_cnt;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   veer_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .trace_rv_i_valid_ip(v_i), .trace_rv_i_insn_ip(insn_i),
      .trace_rv_i_address_ip(addr_i), .trace_rv_i_exception_ip(exc_i),
      .trace_rv_i_ecause_ip(ec_i), .trace_rv_i_interrupt_ip(intr_i),
      .trace_rv_i_tval_ip(tval_i), .flush(flush), .cnt_clr(cnt_clr),
      .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
      .out_address(out_address), .out_exception(out_exception),
      .out_ecause(out_ecause), .out_interrupt(out_interrupt),
      .out_tval(out_tval), .level(level), .retire_cnt(retire_cnt),
      .drop_cnt(drop_cnt), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] insn;
      logic [31:0] addr;
      logic        exc;
      logic [4:0]  ec;
      logic        intr;
      logic [31:0] tval;
   } rec_t;

   rec_t q[$];
   longint m_retire = 0;
   longint m_drop = 0;
   bit     m_ovf = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_retire = 0;
      m_drop = 0;
      m_ovf = 0;
   endtask

   // Queue model of one clock edge, using the inputs held across that edge.
   task automatic model_step();
      bit   full, pop, do_push, drop_ev, ret_ev;
      rec_t r;
      if (rst) begin
         model_reset();
         return;
      end
      full    = (q.size() == DEPTH);
      pop     = (q.size() > 0) && out_ready;
      ret_ev  = v_i && !exc_i && !intr_i;
      do_push = v_i && !flush && (!full || pop);
      drop_ev = v_i && !flush && full && !pop;
      r.insn = insn_i; r.addr = addr_i; r.exc = exc_i;
      r.ec = ec_i; r.intr = intr_i; r.tval = tval_i;
      if (flush) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (do_push) q.push_back(r);
      end
      if (cnt_clr) begin
         m_retire = ret_ev ? 1 : 0;
         m_drop   = drop_ev ? 1 : 0;
         m_ovf    = drop_ev;
      end else begin
         m_retire = (m_retire + (ret_ev ? 1 : 0)) % (64'd1 << CNT_W);
         if (drop_ev && m_drop < (64'd1 << CNT_W) - 1) m_drop++;
         m_ovf = m_ovf | drop_ev;
      end
   endtask

   // Single compare process: every falling edge, DUT outputs against the model.
   always @(negedge clk) begin
      rec_t h;
      h = '{insn: 0, addr: 0, exc: 0, ec: 0, intr: 0, tval: 0};
      if (q.size() > 0) h = q[0];
`ifndef VEER_TRACE_FIFO_TVAL_EN
      h.tval = 0;
`endif
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("level", 64'(level), 64'(q.size()));
      chk("out_insn", 64'(out_insn), 64'(h.insn));
      chk("out_address", 64'(out_address), 64'(h.addr));
      chk("out_exception", 64'(out_exception), 64'(h.exc));
      chk("out_ecause", 64'(out_ecause), 64'(h.ec));
      chk("out_interrupt", 64'(out_interrupt), 64'(h.intr));
      chk("out_tval", 64'(out_tval), 64'(h.tval));
      chk("retire_cnt", 64'(retire_cnt), 64'(m_retire));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("overflow", 64'(overflow), 64'(m_ovf));
   end

   task automatic cyc(input logic v, input logic [31:0] insn, input logic [31:0] addr,
                      input logic exc, input logic [4:0] ec, input logic intr,
                      input logic [31:0] tval, input logic rdy, input logic fl,
                      input logic clr);
      v_i = v; insn_i = insn; addr_i = addr; exc_i = exc; ec_i = ec;
      intr_i = intr; tval_i = tval; out_ready = rdy; flush = fl; cnt_clr = clr;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic push(input logic [31:0] insn, input logic rdy);
      cyc(1, insn, 32'h8000_0000 + insn, 0, 0, 0, 0, rdy, 0, 0);
   endtask

   task automatic idle(input logic rdy);
      cyc(0, 0, 0, 0, 0, 0, 0, rdy, 0, 0);
   endtask

   task automatic do_flush();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
   endtask

   initial begin
      rst = 1'b1;
      model_reset();
      repeat (3) idle(0);
      chk("rst_level", 64'(level), 0);
      chk("rst_valid", 64'(out_valid), 0);
      chk("rst_retire", 64'(retire_cnt), 0);
      rst = 1'b0;

      // First record after reset, one-cycle latency.
      cyc(1, 32'h13, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0);
      chk("t1_valid", 64'(out_valid), 1);
      chk("t1_insn", 64'(out_insn), 64'h13);
      chk("t1_addr", 64'(out_address), 64'h8000_0000);
      chk("t1_level", 64'(level), 1);
      chk("t1_retire", 64'(retire_cnt), 1);

      // Flush + clear together, then fill and overflow by one.
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk("fc_level", 64'(level), 0);
      chk("fc_retire", 64'(retire_cnt), 0);
      for (int i = 0; i < 17; i++) push(32'h100 + i, 0);
      chk("full_level", 64'(level), 16);
      chk("full_drop", 64'(drop_cnt), 1);
      chk("full_ovf", 64'(overflow), 1);
      chk("full_retire", 64'(retire_cnt), 17);

      // Full with push and pop in the same cycle.
      push(32'hAAAA, 1);
      chk("pp_level", 64'(level), 16);
      chk("pp_drop", 64'(drop_cnt), 1);
      chk("pp_head", 64'(out_insn), 64'h101);

      // Drain: 15 pops leave the tail record at the head.
      for (int i = 0; i < 15; i++) idle(1);
      chk("tail_insn", 64'(out_insn), 64'hAAAA);
      idle(1);
      chk("drain_level", 64'(level), 0);
      chk("drain_valid", 64'(out_valid), 0);
      chk("drain_insn", 64'(out_insn), 0);

      // Exception and interrupt records do not retire.
      cyc(1, 32'h0010_0073, 32'h8000_0100, 1, 5'd2, 0, 32'hDEAD_BEEF, 0, 0, 0);
      chk("exc_flag", 64'(out_exception), 1);
      chk("exc_cause", 64'(out_ecause), 2);
      chk("exc_retire", 64'(retire_cnt), 18);
`ifdef VEER_TRACE_FIFO_TVAL_EN
      chk("exc_tval", 64'(out_tval), 64'hDEAD_BEEF);
`else
      chk("exc_tval", 64'(out_tval), 0);
`endif
      cyc(1, 32'h0, 32'h8000_0200, 0, 5'd7, 1, 32'h1234, 0, 0, 0);
      chk("intr_retire", 64'(retire_cnt), 18);
      chk("intr_level", 64'(level), 2);

      // Level 5, flush with a same-cycle push.
      do_flush();
      for (int i = 0; i < 5; i++) push(32'h500 + i, 0);
      chk("l5_level", 64'(level), 5);
      cyc(1, 32'h5FF, 32'h0, 0, 0, 0, 0, 0, 1, 0);
      chk("fp_level", 64'(level), 0);
      chk("fp_drop", 64'(drop_cnt), 1);
      chk("fp_retire", 64'(retire_cnt), 24);

      // Clear together with a drop on a full FIFO.
      for (int i = 0; i < 16; i++) push(32'h600 + i, 0);
      cyc(1, 32'h6FF, 32'h0, 0, 0, 0, 0, 0, 0, 1);
      chk("cd_drop", 64'(drop_cnt), 1);
      chk("cd_ovf", 64'(overflow), 1);
      chk("cd_retire", 64'(retire_cnt), 1);

      // Sustained push and pop every cycle.
      do_flush();
      for (int i = 0; i < 10; i++) push(32'h900 + i, 1);
      chk("tp_level", 64'(level), 1);
      chk("tp_insn", 64'(out_insn), 64'h909);

      // Asynchronous reset mid-drain at level 7.
      do_flush();
      for (int i = 0; i < 7; i++) push(32'h700 + i, 0);
      chk("mr_level", 64'(level), 7);
      out_ready = 1'b1;
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("ar_valid", 64'(out_valid), 0);
      chk("ar_level", 64'(level), 0);
      chk("ar_insn", 64'(out_insn), 0);
      chk("ar_retire", 64'(retire_cnt), 0);
      chk("ar_drop", 64'(drop_cnt), 0);
      chk("ar_ovf", 64'(overflow), 0);
      idle(0);
      rst = 1'b0;
      push(32'h13, 0);
      chk("post_level", 64'(level), 1);
      chk("post_insn", 64'(out_insn), 64'h13);
      idle(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
